// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with enable prescaler, sync load/clear,
// wrap-or-saturate boundary handling, and tick / terminal-count / sticky overflow flags.
module updown_counter_mod #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] MAX_VAL  = 32'hFFFF_FFFF,
  parameter bit          SATURATE = 1'b0,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV  = MAX_VAL[WIDTH-1:0];
  localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic step, at_max, at_zero, boundary;

  assign step     = en && (psc_q == PLAST);
  assign at_max   = (count_q == MAXV);
  assign at_zero  = (count_q == '0);
  assign boundary = up_dn ? at_max : at_zero;

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      psc_d   = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAXV) ? MAXV : load_val;
      psc_d   = '0;
    end else if (step) begin
      psc_d  = '0;
      tick_d = 1'b1;
      tc_d   = boundary;
      if (boundary) begin
        ovf_d = 1'b1;
        // saturate holds the current value; wrap jumps to the opposite end
        if (!SATURATE) count_d = up_dn ? '0 : MAXV;
      end else begin
        count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
      end
    end else if (en) begin
      psc_d = psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      psc_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: four configurations share one stimulus stream and
// are compared against an arithmetic reference model, a vector table and corner sequences.
module tb_updown_counter_mod;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, up_dn = 1'b0, load = 1'b0, clear = 1'b0;
  logic [3:0]  lv4 = '0;
  logic [31:0] lv32 = '0;
  logic [3:0]  cA, cB, cC;
  logic [31:0] cD;
  logic [3:0]  tk, tcs, ov;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(32'd9), .SATURATE(1'b0), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4), .clear(clear),
    .count(cA), .tick(tk[0]), .tc(tcs[0]), .ovf(ov[0]));
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(32'd9), .SATURATE(1'b1), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4), .clear(clear),
    .count(cB), .tick(tk[1]), .tc(tcs[1]), .ovf(ov[1]));
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(32'd9), .SATURATE(1'b0), .PRESCALE(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4), .clear(clear),
    .count(cC), .tick(tk[2]), .tc(tcs[2]), .ovf(ov[2]));
  updown_counter_mod u_d (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv32), .clear(clear),
    .count(cD), .tick(tk[3]), .tc(tcs[3]), .ovf(ov[3]));

  // reference model: count lives in 0..maxv, arithmetic is modulo maxv+1
  longint maxv[4] = '{9, 9, 9, 64'hFFFF_FFFF};
  bit     sat[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  int     ps[4]   = '{1, 1, 4, 1};
  longint m_cnt[4];
  int     m_en_cnt[4];
  bit     m_ovf[4], m_tick[4], m_tc[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_en_cnt[i] = 0; m_ovf[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      longint lv;
      lv = (i == 3) ? longint'(lv32) : longint'(lv4);
      m_tick[i] = 0;
      m_tc[i]   = 0;
      if (clear) begin
        m_cnt[i] = 0; m_en_cnt[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
        m_en_cnt[i] = 0;
      end else if (en) begin
        m_en_cnt[i]++;
        if (m_en_cnt[i] == ps[i]) begin
          bit edge_hit;
          m_en_cnt[i] = 0;
          m_tick[i] = 1;
          edge_hit = up_dn ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0);
          if (edge_hit) begin
            m_tc[i] = 1; m_ovf[i] = 1;
          end
          if (!(edge_hit && sat[i]))
            m_cnt[i] = up_dn ? (m_cnt[i] + 1) % (maxv[i] + 1)
                             : (m_cnt[i] + maxv[i]) % (maxv[i] + 1);
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] act_cnt(int i);
    case (i)
      0: return {60'd0, cA};
      1: return {60'd0, cB};
      2: return {60'd0, cC};
      default: return {32'd0, cD};
    endcase
  endfunction

  task automatic model_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_u%0d_cnt", tag, i), act_cnt(i), 64'(m_cnt[i]));
      chk($sformatf("%s_u%0d_flags", tag, i), {61'd0, tk[i], tcs[i], ov[i]},
          {61'd0, m_tick[i], m_tc[i], m_ovf[i]});
    end
  endtask

  task automatic apply(input bit c, input bit l, input bit e, input bit u, input logic [31:0] lv);
    @(negedge clk);
    clear = c; load = l; en = e; up_dn = u; lv4 = lv[3:0]; lv32 = lv;
    @(posedge clk);
    model_edge();
    #1;
    model_check("mdl");
  endtask

  typedef struct {
    bit c, l, e, u;
    logic [31:0] lv;
    logic [3:0]  cnt;
    bit tick, tc, ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit l, bit e, bit u, logic [31:0] lv,
                              logic [3:0] cnt, bit tick, bit tc, bit ovf);
    vec_t v;
    v.c = c; v.l = l; v.e = e; v.u = u; v.lv = lv;
    v.cnt = cnt; v.tick = tick; v.tc = tc; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    // expectations for the WIDTH=4, MAX_VAL=9, wrap, PRESCALE=1 instance
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 4'(i), 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0,  4'd0, 1, 1, 1));  // 9 -> 0 wraps
    tbl.push_back(mk(0, 0, 0, 1, 0,  4'd0, 0, 0, 1));  // en low holds
    tbl.push_back(mk(0, 0, 1, 0, 0,  4'd9, 1, 1, 1));  // 0 -> 9 down wrap
    tbl.push_back(mk(0, 0, 1, 0, 0,  4'd8, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 12, 4'd9, 0, 0, 1));  // load clamps
    tbl.push_back(mk(0, 1, 1, 1, 3,  4'd3, 0, 0, 1));  // load beats step
    tbl.push_back(mk(1, 1, 1, 1, 5,  4'd0, 0, 0, 0));  // clear beats load
    tbl.push_back(mk(0, 0, 1, 0, 0,  4'd9, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0,  4'd0, 0, 0, 0));

    model_reset();
    repeat (2) @(posedge clk);
    #1 model_check("reset");
    @(negedge clk) rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].c, tbl[k].l, tbl[k].e, tbl[k].u, tbl[k].lv);
      chk($sformatf("tbl%0d_cnt", k), {60'd0, cA}, {60'd0, tbl[k].cnt});
      chk($sformatf("tbl%0d_flags", k), {61'd0, tk[0], tcs[0], ov[0]},
          {61'd0, tbl[k].tick, tbl[k].tc, tbl[k].ovf});
    end

    // saturate variant: down at 0 holds and pulses tc every step
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 1, 0, 0);
      chk($sformatf("sat%0d_cnt", k), {60'd0, cB}, 64'd0);
      chk($sformatf("sat%0d_tc", k), {63'd0, tcs[1]}, 64'd1);
    end

    // prescale 4 with a 3-cycle enable gap: step lands on the 7th cycle
    apply(1, 0, 0, 1, 0);
    begin
      bit pat[7] = '{1, 1, 0, 0, 0, 1, 1};
      for (int k = 0; k < 7; k++) begin
        apply(0, 0, pat[k], 1, 0);
        chk($sformatf("psc%0d_tick", k), {63'd0, tk[2]}, (k == 6) ? 64'd1 : 64'd0);
      end
      chk("psc_cnt", {60'd0, cC}, 64'd1);
    end

    // async reset between edges at count 5
    apply(1, 0, 0, 1, 0);
    repeat (5) apply(0, 0, 1, 1, 0);
    chk("pre_rst_cnt", {60'd0, cA}, 64'd5);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 model_check("async_rst");
    #1 rst = 1'b0;
    apply(0, 0, 1, 1, 0);
    chk("post_rst1", {60'd0, cA}, 64'd1);
    apply(0, 0, 1, 1, 0);
    chk("post_rst2", {60'd0, cA}, 64'd2);

    // 32-bit default instance across the top boundary
    apply(1, 0, 0, 1, 0);
    apply(0, 1, 0, 1, 32'hFFFF_FFFE);
    chk("w32_load", {32'd0, cD}, 64'hFFFF_FFFE);
    apply(0, 0, 1, 1, 0);
    chk("w32_max", {32'd0, cD}, 64'hFFFF_FFFF);
    chk("w32_max_tc", {63'd0, tcs[3]}, 64'd0);
    apply(0, 0, 1, 1, 0);
    chk("w32_wrap", {32'd0, cD}, 64'd0);
    chk("w32_wrap_flags", {62'd0, tcs[3], ov[3]}, 64'd3);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      bit c, l, e, u;
      logic [31:0] lv;
      c  = ($urandom_range(99) < 3);
      l  = ($urandom_range(99) < 6);
      e  = ($urandom_range(99) < 80);
      u  = ($urandom_range(99) < 60);
      lv = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
      apply(c, l, e, u, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
